// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames samples into the FFT core and captures per-bin magnitudes with peak tracking
module fft_frame_ctrl #(
  parameter int N = 128,
  parameter int AW = 7,
  parameter int FEED_LAT = 2,
  parameter int RES_LAT = 1,
  parameter int TIMEOUT = 16383
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          fft_go,
  output logic [7:0]    data1,
  input  logic          fft_done,
  input  logic [15:0]   fft_res,
  output logic          res_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [8:0]    rd_data,
  input  logic          res_ack,
  output logic [AW-1:0] peak_bin,
  output logic [8:0]    peak_mag,
  output logic [7:0]    drop_cnt,
  output logic          err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] IDLE = 4'd0, FILL = 4'd1, GO = 4'd2, WAIT_FEED = 4'd3, FEED = 4'd4,
                         WAIT_DONE = 4'd5, WAIT_RES = 4'd6, CAPTURE = 4'd7, DONE = 4'd8;
  logic [3:0] state;
  logic [AW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic done_q;
  logic [7:0] smem [N];
  logic [8:0] rmem [N];
  logic [7:0] abs_re, abs_im;
  logic [8:0] mag;
  logic [AW-1:0] pk_bin;
  logic [8:0] pk_mag;
  logic last, rise, pk_hit;
  assign s_ready = state == FILL;
  assign fft_go = state == GO;
  assign abs_re = fft_res[15] ? -fft_res[15:8] : fft_res[15:8];
  assign abs_im = fft_res[7] ? -fft_res[7:0] : fft_res[7:0];
  assign mag = {1'b0, abs_re} + {1'b0, abs_im};
  assign last = &cnt;
  assign rise = fft_done & ~done_q;
  assign pk_hit = !cnt[AW-1] && |cnt && mag > pk_mag;
  always_ff @(posedge clk) begin
    if (state == FILL && s_valid) smem[cnt] <= s_data;
    if (state == CAPTURE) rmem[cnt] <= mag;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd_data <= '0;
    else rd_data <= rmem[rd_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      done_q <= 1'b0;
      data1 <= '0;
      res_valid <= 1'b0;
      peak_bin <= '0;
      peak_mag <= '0;
      pk_bin <= '0;
      pk_mag <= '0;
      drop_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      done_q <= fft_done;
      data1 <= '0;
      if (s_valid && state != FILL && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      case (state)
        IDLE: if (enable && !res_valid) begin
          state <= FILL;
          cnt <= '0;
        end
        FILL: if (s_valid) begin
          cnt <= cnt + AW'(1);
          if (last) state <= GO;
        end
        GO: begin
          state <= WAIT_FEED;
          tcnt <= '0;
        end
        WAIT_FEED: if (tcnt == TW'(FEED_LAT - 2)) begin
          state <= FEED;
          cnt <= '0;
          data1 <= smem[0];
        end else tcnt <= tcnt + TW'(1);
        FEED: if (last) begin
          state <= WAIT_DONE;
          tcnt <= '0;
        end else begin
          cnt <= cnt + AW'(1);
          data1 <= smem[cnt + AW'(1)];
        end
        WAIT_DONE: if (rise) begin
          state <= RES_LAT == 1 ? CAPTURE : WAIT_RES;
          tcnt <= '0;
          cnt <= '0;
          pk_bin <= '0;
          pk_mag <= '0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          err_timeout <= 1'b1;
          state <= IDLE;
        end else tcnt <= tcnt + TW'(1);
        WAIT_RES: if (tcnt == TW'(RES_LAT - 2)) state <= CAPTURE;
          else tcnt <= tcnt + TW'(1);
        CAPTURE: begin
          cnt <= cnt + AW'(1);
          if (pk_hit) begin
            pk_bin <= cnt;
            pk_mag <= mag;
          end
          if (last) begin
            state <= DONE;
            res_valid <= 1'b1;
            peak_bin <= pk_hit ? cnt : pk_bin;
            peak_mag <= pk_hit ? mag : pk_mag;
          end
        end
        DONE: if (res_ack) begin
          res_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: drives frames through fft_frame_ctrl with a core model and checks against a magnitude/peak reference
module tb_fft_frame_ctrl;
  localparam int N = 128;
  logic clk = 0, rst_n = 0, enable = 0, s_valid = 0, fft_done = 0, res_ack = 0;
  logic [7:0] s_data = 0;
  logic [15:0] fft_res = 0;
  logic [6:0] rd_addr = 0;
  logic s_ready, fft_go, res_valid, err_timeout;
  logic [7:0] data1, drop_cnt;
  logic [8:0] rd_data, peak_mag;
  logic [6:0] peak_bin;
  logic [7:0] smp [N];
  logic [15:0] res [N];
  int ncmp = 0, nerr = 0, exp_drop = 0;

  fft_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .fft_go(fft_go), .data1(data1), .fft_done(fft_done), .fft_res(fft_res),
    .res_valid(res_valid), .rd_addr(rd_addr), .rd_data(rd_data), .res_ack(res_ack),
    .peak_bin(peak_bin), .peak_mag(peak_mag), .drop_cnt(drop_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ncmp++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int mag_of(input logic [15:0] w);
    int re = $signed(w[15:8]);
    int im = $signed(w[7:0]);
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
  endfunction

  function automatic int sat_add(input int a, input int b);
    return a + b > 255 ? 255 : a + b;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 50 && s_ready !== 1'b1; i++) tick();
    chk("s_ready_up", s_ready, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_fft_go"}, fft_go, 0);
    chk({tag, "_data1"}, data1, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_mag"}, peak_mag, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Offer all N samples (optionally with random idle beats); ends at the first FEED cycle.
  task automatic fill(input bit gaps);
    int i = 0;
    int guard = 0;
    wait_ready();
    while (i < N && guard < 2000) begin
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_data = smp[i];
      tick();
      if (s_valid) i++;
      guard++;
    end
    s_valid = 0;
    chk("fft_go_pulse", fft_go, 1);
    chk("s_ready_after_fill", s_ready, 0);
    tick();
    chk("fft_go_one_cycle", fft_go, 0);
    chk("data1_before_feed", data1, 0);
    tick();
  endtask

  task automatic feed_check(input int upto);
    for (int k = 0; k < upto; k++) begin
      chk($sformatf("data1[%0d]", k), data1, smp[k]);
      tick();
    end
  endtask

  task automatic check_results();
    int m [N];
    int best = 0;
    int bi = 0;
    for (int b = 0; b < N; b++) m[b] = mag_of(res[b]);
    for (int b = 1; b < N / 2; b++) best = m[b] > best ? m[b] : best;
    for (int b = N / 2 - 1; b >= 1; b--) if (best != 0 && m[b] == best) bi = b;
    chk("peak_bin", peak_bin, bi);
    chk("peak_mag", peak_mag, best);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("err_timeout_clear", err_timeout, 0);
    for (int a = 0; a < N; a++) begin
      rd_addr = 7'(a);
      tick();
      chk($sformatf("rd_data[%0d]", a), rd_data, m[a]);
    end
  endtask

  // Core model: pre cycles of silence (optionally offering dropped beats), a rising fft_done,
  // one junk cycle, then N result words; fft_done stays high for the first `hold` words.
  task automatic capture(input int pre, input int hold, input bit drops);
    s_valid = drops;
    repeat (pre) tick();
    s_valid = 0;
    if (drops) exp_drop = sat_add(exp_drop, pre);
    fft_done = 1;
    fft_res = 16'($urandom);
    tick();
    for (int b = 0; b < N; b++) begin
      fft_res = res[b];
      if (b >= hold) fft_done = 0;
      if (b == N - 1) chk("res_valid_early", res_valid, 0);
      tick();
    end
    fft_done = 0;
    fft_res = 0;
    chk("res_valid_set", res_valid, 1);
    check_results();
  endtask

  task automatic ack(input int drops);
    s_valid = 1;
    repeat (drops) tick();
    s_valid = 0;
    exp_drop = sat_add(exp_drop, drops);
    chk("drop_cnt_done", drop_cnt, exp_drop);
    chk("res_valid_held", res_valid, 1);
    res_ack = 1;
    tick();
    res_ack = 0;
    chk("res_valid_cleared", res_valid, 0);
  endtask

  task automatic clear_res();
    for (int b = 0; b < N; b++) res[b] = 16'h0000;
  endtask

  task automatic rand_smp();
    for (int k = 0; k < N; k++) smp[k] = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1;
    repeat (3) tick();
    chk("idle_no_enable", s_ready, 0);
    enable = 1;

    // Ramp frame, single non-zero bin
    for (int k = 0; k < N; k++) smp[k] = 8'(k);
    clear_res();
    res[5] = {8'sd100, -8'sd50};
    fill(0);
    feed_check(N);
    chk("data1_after_feed", data1, 0);
    capture(3, N, 0);
    ack(5);

    // Tie at full scale; fft_done falls early; overflow drops; ack while idle-side ignored
    rand_smp();
    clear_res();
    res[3] = 16'h8080;
    res[7] = 16'h8080;
    res_ack = 1;
    fill(1);
    res_ack = 0;
    feed_check(N);
    capture(300, 40, 1);
    ack(0);

    // DC and mirror exclusion; fft_done already high on WAIT_DONE entry
    rand_smp();
    clear_res();
    res[0] = 16'h7f7f;
    res[10] = 16'h0100;
    res[64] = 16'h6464;
    res[127] = 16'h7f00;
    fill(1);
    fft_done = 1;
    feed_check(N);
    repeat (5) tick();
    fft_done = 0;
    capture(2, N, 0);
    ack(3);

    // Fully random frame; enable drops mid-frame without aborting it
    rand_smp();
    for (int b = 0; b < N; b++) res[b] = 16'($urandom);
    fill(1);
    enable = 0;
    feed_check(N);
    capture($urandom_range(0, 20), N, 0);
    ack(0);
    repeat (4) tick();
    chk("idle_enable_low", s_ready, 0);
    enable = 1;

    // Core never answers
    rand_smp();
    fill(1);
    feed_check(N);
    repeat (16382) tick();
    chk("no_timeout_yet", err_timeout, 0);
    tick();
    chk("timeout_set", err_timeout, 1);
    chk("timeout_idle", s_ready, 0);
    chk("timeout_no_result", res_valid, 0);

    // Reset mid-FEED
    rand_smp();
    fill(0);
    feed_check(20);
    chk("timeout_sticky", err_timeout, 1);
    enable = 0;
    rst_n = 0;
    #1;
    exp_drop = 0;
    check_zero("midreset");
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("post_reset_idle", s_ready, 0);
    enable = 1;

    // Clean random frame after reset
    rand_smp();
    for (int b = 0; b < N; b++) res[b] = 16'($urandom);
    fill(1);
    feed_check(N);
    capture($urandom_range(0, 10), N, 0);
    ack(0);
    wait_ready();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
